cache_set_ctrl: RTL and testbench

Sequencing controller for the 8-way, 64-set, 64-byte-line L1 data array. Accepts one CPU load/store at a time and owns the tag/valid/dirty store and the per-set victim pointers. Drives the data array through hit access, dirty-line writeback, line fill and replay, and talks to next-level memory over a req/ack line interface.

---
 rtl/cache_pkg.sv | 54 +++++
 rtl/cache_tag_store.sv | 89 ++++++++
 rtl/cache_set_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_cache_set_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and array/size encodings for the L1 set controller.
// Also holds the line-crossing check and the load-data size mask used by the top.
package cache_pkg;

    localparam int SETS       = 64;
    localparam int LINE_BYTES = 64;
    localparam int OFF_W      = 6;
    localparam int SET_W      = 6;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP,
        S_WB_RD,
        S_WB_REQ,
        S_FILL_REQ,
        S_FILL_WR,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_WORD_RD   = 2'd0,
        OP_WORD_WR   = 2'd1,
        OP_LINE_RD   = 2'd2,
        OP_LINE_FILL = 2'd3
    } arr_op_t;

    typedef enum logic [1:0] {
        SZ_1B = 2'd0,
        SZ_2B = 2'd1,
        SZ_4B = 2'd2,
        SZ_8B = 2'd3
    } size_code_t;

    // True when the access would spill past the last byte of its line.
    function automatic logic crosses_line(input logic [OFF_W-1:0] offset, input logic [1:0] size);
        logic [OFF_W:0] end_off;
        end_off = {1'b0, offset} + ((OFF_W + 1)'(1) << size);
        return end_off > (OFF_W + 1)'(LINE_BYTES);
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] mask;
        case (size)
            SZ_1B:   mask = 64'h0000_0000_0000_00FF;
            SZ_2B:   mask = 64'h0000_0000_0000_FFFF;
            SZ_4B:   mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/valid/dirty arrays plus per-set round-robin victim pointers.
// Lookup and victim selection are combinational on the currently presented set/tag.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int TAG_W = 20,
    parameter int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] lookup_set,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid,
    output logic             victim_dirty,
    output logic [TAG_W-1:0] victim_tag,
    input  logic             mark_dirty,
    input  logic [WAY_W-1:0] mark_way,
    input  logic             fill,
    input  logic [WAY_W-1:0] fill_way,
    input  logic             fill_bump_rr
);

    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]  valid_mem [SETS];
    logic [WAYS-1:0]  dirty_mem [SETS];
    logic [WAY_W-1:0] rr_ptr    [SETS];

    logic [WAYS-1:0]  set_valid;
    logic             free_found;
    logic [WAY_W-1:0] free_way;

    assign set_valid = valid_mem[lookup_set];

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_valid[w] && (tag_mem[lookup_set][w] == lookup_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    assign victim_way   = free_found ? free_way : rr_ptr[lookup_set];
    assign victim_valid = set_valid[victim_way];
    assign victim_dirty = dirty_mem[lookup_set][victim_way];
    assign victim_tag   = tag_mem[lookup_set][victim_way];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                rr_ptr[s]    <= '0;
            end
        end else begin
            if (mark_dirty) begin
                dirty_mem[lookup_set][mark_way] <= 1'b1;
            end
            if (fill) begin
                valid_mem[lookup_set][fill_way] <= 1'b1;
                dirty_mem[lookup_set][fill_way] <= 1'b0;
                if (fill_bump_rr) begin
                    rr_ptr[lookup_set] <= rr_ptr[lookup_set] + WAY_W'(1);
                end
            end
        end
    end

    // Tags need no reset: a way is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[lookup_set][fill_way] <= lookup_tag;
        end
    end

endmodule

// File: rtl/cache_set_ctrl.sv
// Single-outstanding L1 sequencing controller: hit access, dirty writeback,
// line fill and replay against an 8-way set-associative data array.
module cache_set_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WAYS   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [1:0]               cpu_size,
    input  logic [63:0]              cpu_wdata,
    output logic                     rsp_valid,
    output logic [63:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic                     arr_en,
    output logic [1:0]               arr_op,
    output logic [SET_W-1:0]         arr_set,
    output logic [$clog2(WAYS)-1:0]  arr_way,
    output logic [OFF_W-1:0]         arr_offset,
    output logic [1:0]               arr_size,
    output logic [63:0]              arr_wdata,
    output logic [LINE_W-1:0]        arr_wline,
    input  logic [63:0]              arr_rdata,
    input  logic [LINE_W-1:0]        arr_rline,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wline,
    input  logic                     mem_ack,
    input  logic [LINE_W-1:0]        mem_rline
);

    localparam int TAG_W = ADDR_W - OFF_W - SET_W;
    localparam int WAY_W = $clog2(WAYS);

    state_t state, state_next;

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [63:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic [SET_W-1:0]  req_set;
    logic [OFF_W-1:0]  req_off;

    logic              wb_phase;
    logic [WAY_W-1:0]  vic_way;
    logic              vic_valid;
    logic [TAG_W-1:0]  vic_tag;
    logic [LINE_W-1:0] wb_line;
    logic [LINE_W-1:0] fill_line;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    logic              victim_valid;
    logic              victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic              mark_dirty;
    logic              fill;

    assign req_tag   = req_addr[ADDR_W-1:OFF_W+SET_W];
    assign req_set   = req_addr[OFF_W+SET_W-1:OFF_W];
    assign req_off   = req_addr[OFF_W-1:0];
    assign mem_wline = wb_line;

    cache_tag_store #(
        .TAG_W(TAG_W),
        .WAYS (WAYS)
    ) u_tags (
        .clk         (clk),
        .rst         (rst),
        .lookup_set  (req_set),
        .lookup_tag  (req_tag),
        .hit         (hit),
        .hit_way     (hit_way),
        .victim_way  (victim_way),
        .victim_valid(victim_valid),
        .victim_dirty(victim_dirty),
        .victim_tag  (victim_tag),
        .mark_dirty  (mark_dirty),
        .mark_way    (hit_way),
        .fill        (fill),
        .fill_way    (vic_way),
        .fill_bump_rr(vic_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_size  <= '0;
            req_wdata <= '0;
            wb_phase  <= 1'b0;
            vic_way   <= '0;
            vic_valid <= 1'b0;
            vic_tag   <= '0;
            wb_line   <= '0;
            fill_line <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (cpu_valid) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_size  <= cpu_size;
                        req_wdata <= cpu_wdata;
                    end
                end
                S_LOOKUP: begin
                    if (!hit) begin
                        vic_way   <= victim_way;
                        vic_valid <= victim_valid;
                        vic_tag   <= victim_tag;
                    end
                end
                // Second WB_RD cycle is when the line read data is on arr_rline.
                S_WB_RD: begin
                    wb_phase <= !wb_phase;
                    if (wb_phase) begin
                        wb_line <= arr_rline;
                    end
                end
                S_FILL_REQ: begin
                    if (mem_ack) begin
                        fill_line <= mem_rline;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        arr_en     = 1'b0;
        arr_op     = OP_WORD_RD;
        arr_set    = '0;
        arr_way    = '0;
        arr_offset = '0;
        arr_size   = '0;
        arr_wdata  = '0;
        arr_wline  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mark_dirty = 1'b0;
        fill       = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_valid) begin
                    state_next = crosses_line(cpu_addr[OFF_W-1:0], cpu_size) ? S_ERR : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    arr_en     = 1'b1;
                    arr_op     = req_we ? OP_WORD_WR : OP_WORD_RD;
                    arr_set    = req_set;
                    arr_way    = hit_way;
                    arr_offset = req_off;
                    arr_size   = req_size;
                    arr_wdata  = req_we ? req_wdata : 64'd0;
                    mark_dirty = req_we;
                    state_next = S_RESP;
                end else begin
                    state_next = (victim_valid && victim_dirty) ? S_WB_RD : S_FILL_REQ;
                end
            end
            S_WB_RD: begin
                if (!wb_phase) begin
                    arr_en  = 1'b1;
                    arr_op  = OP_LINE_RD;
                    arr_set = req_set;
                    arr_way = vic_way;
                end else begin
                    state_next = S_WB_REQ;
                end
            end
            S_WB_REQ: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {vic_tag, req_set, {OFF_W{1'b0}}};
                if (mem_ack) begin
                    state_next = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_set, {OFF_W{1'b0}}};
                if (mem_ack) begin
                    state_next = S_FILL_WR;
                end
            end
            // After the fill the request is replayed through LOOKUP and must hit.
            S_FILL_WR: begin
                arr_en     = 1'b1;
                arr_op     = OP_LINE_FILL;
                arr_set    = req_set;
                arr_way    = vic_way;
                arr_wline  = fill_line;
                fill       = 1'b1;
                state_next = S_LOOKUP;
            end
            S_RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = req_we ? 64'd0 : (arr_rdata & size_mask(req_size));
                state_next = S_IDLE;
            end
            S_ERR: begin
                rsp_valid  = 1'b1;
                rsp_err    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Randomised and directed bench for cache_set_ctrl: behavioural data array and memory,
// plus a set/way/golden-image reference model that predicts responses and memory traffic.
module tb_cache_set_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_valid;
    logic          cpu_ready;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [1:0]    cpu_size;
    logic [63:0]   cpu_wdata;
    logic          rsp_valid;
    logic [63:0]   rsp_rdata;
    logic          rsp_err;
    logic          arr_en;
    logic [1:0]    arr_op;
    logic [5:0]    arr_set;
    logic [2:0]    arr_way;
    logic [5:0]    arr_offset;
    logic [1:0]    arr_size;
    logic [63:0]   arr_wdata;
    logic [511:0]  arr_wline;
    logic [63:0]   arr_rdata;
    logic [511:0]  arr_rline;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [511:0]  mem_wline;
    logic          mem_ack;
    logic [511:0]  mem_rline;

    cache_set_ctrl #(.ADDR_W(32), .WAYS(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_size(cpu_size), .cpu_wdata(cpu_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .arr_en(arr_en), .arr_op(arr_op), .arr_set(arr_set), .arr_way(arr_way),
        .arr_offset(arr_offset), .arr_size(arr_size), .arr_wdata(arr_wdata),
        .arr_wline(arr_wline), .arr_rdata(arr_rdata), .arr_rline(arr_rline),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wline(mem_wline), .mem_ack(mem_ack), .mem_rline(mem_rline)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural data array: reads return data one cycle after the strobe.
    logic [511:0] data_arr [64][8];
    int arr_ops = 0;

    always @(posedge clk) begin
        if (arr_en) begin
            arr_ops <= arr_ops + 1;
            case (arr_op)
                2'd0: arr_rdata <= 64'(data_arr[arr_set][arr_way] >> (8 * int'(arr_offset)));
                2'd1: begin
                    for (int k = 0; k < 8; k++) begin
                        if (k < (1 << arr_size) && (int'(arr_offset) + k) < 64)
                            data_arr[arr_set][arr_way][8 * (int'(arr_offset) + k) +: 8] <= arr_wdata[8 * k +: 8];
                    end
                end
                2'd2: arr_rline <= data_arr[arr_set][arr_way];
                default: data_arr[arr_set][arr_way] <= arr_wline;
            endcase
        end
    end

    // Reference model: backing memory, coherent golden image, per-set way state.
    logic [511:0] backing [bit [31:0]];
    logic [511:0] golden  [bit [31:0]];
    bit           m_valid [64][8];
    bit           m_dirty [64][8];
    logic [19:0]  m_tag   [64][8];
    int           m_rr    [64];

    logic [63:0]  last_rdata;
    logic [31:0]  last_wb_addr;
    logic [511:0] last_wb_line;

    function automatic logic [511:0] line_default(input bit [31:0] la);
        logic [511:0] l;
        for (int i = 0; i < 16; i++)
            l[32 * i +: 32] = (la * 32'd2654435761) ^ (32'(i) << 24) ^ 32'(i + 7);
        return l;
    endfunction

    function automatic logic [511:0] mem_line(input bit [31:0] la);
        return backing.exists(la) ? backing[la] : line_default(la);
    endfunction

    function automatic logic [511:0] gold_line(input bit [31:0] la);
        return golden.exists(la) ? golden[la] : mem_line(la);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 8; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
            end
        end
        golden.delete();
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic [63:0] wdata);
        bit [31:0]    la;
        int           set;
        int           off;
        int           nbytes;
        bit           exp_err;
        bit           exp_hit;
        int           vic;
        logic [511:0] line;
        logic [63:0]  exp_rdata;
        bit [31:0]    exp_maddr [$];
        bit           exp_mwe [$];
        logic [511:0] exp_wline [$];
        int           guard;
        int           cycles;
        int           ops0;
        int           midx;
        int           wait_cnt;
        bit           done;
        bit           active;

        la        = {addr[31:6], 6'b0};
        set       = int'(addr[11:6]);
        off       = int'(addr[5:0]);
        nbytes    = 1 << size;
        exp_err   = (off + nbytes) > 64;
        exp_hit   = 1'b0;
        exp_rdata = '0;
        vic       = -1;

        if (!exp_err) begin
            for (int w = 0; w < 8; w++)
                if (m_valid[set][w] && m_tag[set][w] == addr[31:12]) begin
                    exp_hit = 1'b1;
                    vic     = w;
                end
            if (!exp_hit) begin
                for (int w = 7; w >= 0; w--)
                    if (!m_valid[set][w]) vic = w;
                if (vic < 0) vic = m_rr[set];
                if (m_valid[set][vic] && m_dirty[set][vic]) begin
                    exp_maddr.push_back({m_tag[set][vic], addr[11:6], 6'b0});
                    exp_mwe.push_back(1'b1);
                    exp_wline.push_back(gold_line({m_tag[set][vic], addr[11:6], 6'b0}));
                end
                exp_maddr.push_back(la);
                exp_mwe.push_back(1'b0);
                exp_wline.push_back('0);
                if (m_valid[set][vic]) m_rr[set] = (m_rr[set] + 1) % 8;
                m_valid[set][vic] = 1'b1;
                m_dirty[set][vic] = 1'b0;
                m_tag[set][vic]   = addr[31:12];
            end
            line = gold_line(la);
            if (we) begin
                for (int k = 0; k < nbytes; k++) line[8 * (off + k) +: 8] = wdata[8 * k +: 8];
                golden[la]        = line;
                m_dirty[set][vic] = 1'b1;
            end else begin
                for (int k = 0; k < nbytes; k++) exp_rdata[8 * k +: 8] = line[8 * (off + k) +: 8];
            end
        end

        guard = 0;
        while (!cpu_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready", cpu_ready, 1'b1);
        ops0      = arr_ops;
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_size  = size;
        cpu_wdata = wdata;
        @(negedge clk);

        cycles = 1;
        done   = 1'b0;
        active = 1'b0;
        midx   = 0;
        wait_cnt = 0;
        while (!done && cycles < 400) begin
            mem_ack = 1'b0;
            if (rsp_valid) begin
                done      = 1'b1;
                cpu_valid = 1'b0;
            end else begin
                if (mem_req) begin
                    if (!active) begin
                        active   = 1'b1;
                        wait_cnt = $urandom_range(0, 3);
                        if (midx < exp_maddr.size()) begin
                            checkOutput("mem_we", mem_we, exp_mwe[midx]);
                            checkOutput("mem_addr", mem_addr, exp_maddr[midx]);
                            if (exp_mwe[midx]) checkOutput("wb_line", mem_wline, exp_wline[midx]);
                        end
                        if (mem_we) begin
                            last_wb_addr = mem_addr;
                            last_wb_line = mem_wline;
                        end
                    end
                    if (wait_cnt == 0) begin
                        mem_ack = 1'b1;
                        if (mem_we) backing[mem_addr] = mem_wline;
                        else        mem_rline = mem_line(mem_addr);
                        active = 1'b0;
                        midx++;
                    end else begin
                        wait_cnt--;
                    end
                end
                cpu_valid = 1'($urandom_range(0, 1));
                cpu_we    = 1'($urandom);
                cpu_addr  = $urandom;
                cpu_size  = 2'($urandom);
                cpu_wdata = {$urandom, $urandom};
                @(negedge clk);
                cycles++;
            end
        end
        mem_ack    = 1'b0;
        last_rdata = rsp_rdata;

        checkOutput("rsp_seen", done, 1'b1);
        checkOutput("rsp_err", rsp_err, exp_err);
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("mem_count", midx, exp_maddr.size());
        if (exp_err) begin
            checkOutput("err_lat", cycles, 1);
            checkOutput("err_arr", arr_ops - ops0, 0);
        end else if (exp_hit) begin
            checkOutput("hit_lat", cycles, 2);
        end

        @(negedge clk);
        checkOutput("rsp_pulse", rsp_valid, 1'b0);
        checkOutput("ready_back", cpu_ready, 1'b1);
    endtask

    initial begin
        int guard;
        logic [1:0]  sz;
        logic [31:0] a;
        int          o;

        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_size  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rline = '0;
        last_rdata   = '0;
        last_wb_addr = '0;
        last_wb_line = '0;
        model_reset();
        backing[32'h0001_2040] = line_default(32'h0001_2040);
        backing[32'h0001_2040][63:0] = 64'h1122_3344_5566_7788;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", cpu_ready, 1'b1);
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_rsp_err", rsp_err, 1'b0);
        checkOutput("rst_rdata", rsp_rdata, 64'd0);
        checkOutput("rst_arr_en", arr_en, 1'b0);
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wline", mem_wline, 512'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed sequence");
        applyStimulus(1'b0, 32'h0001_2040, 2'd3, 64'd0);
        checkOutput("cold_data", last_rdata, 64'h1122_3344_5566_7788);
        applyStimulus(1'b0, 32'h0001_2040, 2'd3, 64'd0);
        applyStimulus(1'b1, 32'h0001_2044, 2'd1, 64'h0000_0000_0000_BEEF);
        applyStimulus(1'b0, 32'h0001_2045, 2'd0, 64'd0);
        checkOutput("byte_be", last_rdata, 64'h0000_0000_0000_00BE);

        for (int t = 'h13; t <= 'h1A; t++)
            applyStimulus(1'b0, (32'(t) << 12) | 32'h40, 2'd2, 64'd0);
        checkOutput("wb_addr", last_wb_addr, 32'h0001_2040);
        checkOutput("wb_data", last_wb_line[63:0], 64'h1122_BEEF_5566_7788);
        applyStimulus(1'b0, 32'h0001_B040, 2'd3, 64'd0);

        applyStimulus(1'b0, 32'h0001_207E, 2'd2, 64'd0);
        applyStimulus(1'b1, 32'h0001_4040, 2'd3, 64'hCAFE_F00D_1234_5678);

        // Reset while the dirty-victim writeback is pending with no ack.
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0001_C040;
        cpu_size  = 2'd3;
        @(negedge clk);
        cpu_valid = 1'b0;
        guard = 0;
        while (!(mem_req && mem_we) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("wbreq_seen", mem_req && mem_we, 1'b1);
        checkOutput("wbreq_addr", mem_addr, 32'h0001_4040);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_mem_req", mem_req, 1'b0);
        checkOutput("midrst_ready", cpu_ready, 1'b1);
        checkOutput("midrst_rsp", rsp_valid, 1'b0);
        model_reset();
        applyStimulus(1'b0, 32'h0001_2040, 2'd3, 64'd0);
        checkOutput("reload", last_rdata, 64'h1122_BEEF_5566_7788);

        $display("[TB] random sequence");
        for (int n = 0; n < 220; n++) begin
            sz = 2'($urandom);
            o  = $urandom_range(0, 63);
            if ($urandom_range(0, 7) != 0) o = o & ~((1 << sz) - 1);
            a  = (32'($urandom_range('h20, 'h2B)) << 12) | (32'($urandom_range(1, 3)) << 6) | 32'(o);
            applyStimulus(1'($urandom), a, sz, {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
